// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: instruction memory read handshake plus the IR, decode and redirect signals.
// master is the fetch sequencer; slave is the memory/decode/execute environment.
interface fetch_ctrl_if;
  logic        mem_read;
  logic [15:0] mem_address;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        ir_load;
  logic [15:0] ir_in;
  logic        ir_valid;
  logic        decode_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] pc_out;

  modport master (
    output mem_read,
    output mem_address,
    output ir_load,
    output ir_in,
    output ir_valid,
    output pc_out,
    input  mem_resp,
    input  mem_rdata,
    input  decode_ready,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  mem_read,
    input  mem_address,
    input  ir_load,
    input  ir_in,
    input  ir_valid,
    input  pc_out,
    output mem_resp,
    output mem_rdata,
    output decode_ready,
    output redirect,
    output redirect_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// LC-3b instruction fetch sequencer: fetch PC, memory read handshake, IR load and redirect squash.
// Optional FETCH_CTRL_PERF_EN adds fetch_count / stall_count performance counters.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.master bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [15:0]  fetch_count,
  output logic [15:0]  stall_count
`endif
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  localparam logic [15:0] ResetPcAligned = RESET_PC & 16'hFFFE;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;          // architectural next fetch address
  logic [15:0] req_q, req_d;        // address of the access currently on the bus
  logic [15:0] pc_out_q, pc_out_d;
  logic        squash_q, squash_d;

  logic [15:0] redirect_target;
  logic        fetching;
  logic        load;

  assign redirect_target = bus.redirect_pc & 16'hFFFE;
  assign fetching        = (state_q == StFetch);
  // A redirect arriving with the response makes that data stale as well.
  assign load            = fetching & bus.mem_resp & ~squash_q & ~bus.redirect;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    pc_out_d = pc_out_q;
    squash_d = squash_q;
    case (state_q)
      StIdle: begin
        if (bus.redirect) begin
          pc_d = redirect_target;
        end
        req_d   = pc_d;
        state_d = StFetch;
      end
      StFetch: begin
        if (bus.redirect) begin
          pc_d = redirect_target;
        end
        if (bus.mem_resp) begin
          squash_d = 1'b0;
          if (load) begin
            pc_out_d = req_q;
            pc_d     = req_q + 16'd2;
            state_d  = StHold;
          end else begin
            // Discarded response: reissue at the pending redirect target.
            req_d = pc_d;
          end
        end else if (bus.redirect) begin
          squash_d = 1'b1;
        end
      end
      StHold: begin
        if (bus.redirect) begin
          pc_d    = redirect_target;
          req_d   = redirect_target;
          state_d = StFetch;
        end else if (bus.decode_ready) begin
          req_d   = pc_q;
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= ResetPcAligned;
      req_q    <= ResetPcAligned;
      pc_out_q <= ResetPcAligned;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      pc_out_q <= pc_out_d;
      squash_q <= squash_d;
    end
  end

  assign bus.mem_read    = fetching;
  assign bus.mem_address = req_q;
  assign bus.ir_load     = load;
  assign bus.ir_in       = bus.mem_rdata;
  assign bus.ir_valid    = (state_q == StHold);
  assign bus.pc_out      = pc_out_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] fetch_count_q, stall_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= 16'h0000;
      stall_count_q <= 16'h0000;
    end else begin
      if (load) begin
        fetch_count_q <= fetch_count_q + 16'd1;
      end
      if (fetching && !bus.mem_resp) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

  // The outstanding access cannot be aborted, so its address must not move while waiting.
  a_addr_stable: assert property (@(posedge clk) disable iff (reset)
    (fetching && !bus.mem_resp) |=> (!fetching || (req_q == $past(req_q))));

  a_addr_even: assert property (@(posedge clk) disable iff (reset)
    !fetching || !req_q[0]);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a driver plays memory/decode/execute and predicts loads,
// a negedge monitor checks ir_load/ir_in/pc_out/ir_valid against a transaction-level model.
module tb_fetch_ctrl;
  localparam logic [15:0] TbResetPc = 16'hFFFE;
  localparam int unsigned NumCycles = 4000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();
`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  fetch_ctrl #(
    .RESET_PC (TbResetPc)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned loads_seen = 0;
  logic [31:0] exp_q[$];  // {address, data} of each load the model predicts
  logic        mon_en = 1'b0;
  logic        done = 1'b0;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: issues responses, redirects, decode accepts and resets; model of the fetch stream.
  initial begin : driver
    logic [15:0] exp_pc, req_addr, rpc;
    logic        req_active, req_dead, accept_prev;
    int unsigned wait_left, rst_age, dr_burst;

    reset            = 1'b1;
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = 16'h0000;
    bus.decode_ready = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 16'h0000;
    exp_pc      = TbResetPc;
    req_addr    = TbResetPc;
    req_active  = 1'b0;
    req_dead    = 1'b0;
    accept_prev = 1'b0;
    wait_left   = 0;
    rst_age     = 0;
    dr_burst    = 0;

    for (int cyc = 0; cyc < NumCycles; cyc++) begin
      @(posedge clk);
      #1;
      if (reset) begin
        // Reset took effect on this edge: block sits in IDLE for one cycle.
        check1("idle_after_reset", bus.mem_read, 1'b0);
        reset            = 1'b0;
        mon_en           = 1'b1;
        rst_age          = 1;
        exp_pc           = TbResetPc;
        req_active       = 1'b0;
        req_dead         = 1'b0;
        accept_prev      = 1'b0;
        bus.mem_resp     = 1'b0;
        bus.redirect     = 1'b0;
        bus.decode_ready = 1'($urandom_range(0, 1));
        continue;
      end

      if (rst_age == 1) begin
        check1("read_2nd_cycle_after_reset", bus.mem_read, 1'b1);
        rst_age = 0;
      end
      if (accept_prev) begin
        check1("read_after_accept", bus.mem_read, 1'b1);
      end

      if (bus.mem_read) begin
        if (!req_active) begin
          check16("req_address", bus.mem_address, exp_pc);
          req_active = 1'b1;
          req_addr   = exp_pc;
          req_dead   = 1'b0;
          wait_left  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 3);
        end else begin
          check16("address_stable", bus.mem_address, req_addr);
        end
      end else if (req_active) begin
        check1("read_held_until_resp", bus.mem_read, 1'b1);
        req_active = 1'b0;
      end

      if (req_active && wait_left > 0 && $urandom_range(0, 99) == 0) begin
        reset            = 1'b1;
        bus.mem_resp     = 1'b0;
        bus.redirect     = 1'b0;
        bus.decode_ready = 1'b0;
        accept_prev      = 1'b0;
        continue;
      end

      case ($urandom_range(0, 3))
        0:       rpc = 16'hFFFF;
        1:       rpc = 16'h1235;
        default: rpc = 16'($urandom);
      endcase
      bus.redirect_pc = rpc;
      bus.redirect    = (bus.mem_read || bus.ir_valid) && ($urandom_range(0, 11) == 0);

      if (dr_burst > 0) begin
        bus.decode_ready = 1'b0;
        dr_burst--;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.decode_ready = 1'b0;
        dr_burst = 5;
      end else begin
        bus.decode_ready = ($urandom_range(0, 3) != 0);
      end

      bus.mem_resp  = 1'b0;
      bus.mem_rdata = 16'($urandom);
      if (req_active) begin
        if (wait_left == 0) begin
          bus.mem_resp = 1'b1;
          // Data is delivered only if no redirect hit this access, including this cycle.
          if (!req_dead && !bus.redirect) begin
            exp_q.push_back({req_addr, bus.mem_rdata});
            exp_pc = req_addr + 16'd2;
          end
          req_active = 1'b0;
        end else begin
          wait_left--;
        end
      end
      if (bus.redirect) begin
        exp_pc = rpc & 16'hFFFE;
        if (req_active) begin
          req_dead = 1'b1;
        end
      end
      accept_prev = bus.ir_valid && (bus.decode_ready || bus.redirect);
    end

    done = 1'b1;
    @(negedge clk);
    #1;
    check1("progress", (loads_seen > 100), 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Monitor: pops predicted loads and tracks the visible IR state between loads.
  initial begin : monitor
    logic        hold_m;
    logic [15:0] exp_pc_out;
    logic [15:0] fc_m, sc_m;
    logic [31:0] e;
    logic        expected_load;

    hold_m     = 1'b0;
    exp_pc_out = TbResetPc;
    fc_m       = 16'h0000;
    sc_m       = 16'h0000;
    e          = 32'h0;
    while (!done) begin
      @(negedge clk);
      if (!mon_en || done) begin
        continue;
      end
      check1("ir_valid", bus.ir_valid, hold_m);
      check16("pc_out", bus.pc_out, exp_pc_out);
      check1("read_and_valid_exclusive", bus.mem_read & bus.ir_valid, 1'b0);
`ifdef FETCH_CTRL_PERF_EN
      check16("fetch_count", fetch_count, fc_m);
      check16("stall_count", stall_count, sc_m);
`endif
      if (bus.ir_load) begin
        loads_seen++;
      end
      expected_load = (exp_q.size() != 0);
      if (expected_load) begin
        e = exp_q.pop_front();
        check1("ir_load", bus.ir_load, 1'b1);
        check16("ir_in", bus.ir_in, e[15:0]);
      end else begin
        check1("spurious_ir_load", bus.ir_load, 1'b0);
      end

      if (reset) begin
        hold_m     = 1'b0;
        exp_pc_out = TbResetPc;
        fc_m       = 16'h0000;
        sc_m       = 16'h0000;
        exp_q.delete();
      end else begin
        if (expected_load) begin
          hold_m     = 1'b1;
          exp_pc_out = e[31:16];
          fc_m       = fc_m + 16'd1;
        end else if (hold_m && (bus.decode_ready || bus.redirect)) begin
          hold_m = 1'b0;
        end
        if (bus.mem_read && !bus.mem_resp) begin
          sc_m = sc_m + 16'd1;
        end
      end
    end
  end

endmodule
